// File: rtl/adc_conv_sched.sv
// ADC conversion scheduler: periodic capacitor/power scans plus host-requested
// conversions, arbitrated onto one serial ADC engine with a completion timeout.
module adc_conv_sched #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned TIMEOUT  = 4096,
  parameter logic [7:0]  CAP_FULL = 8'd200,
  parameter logic [7:0]  POW_LOW  = 8'd150
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       host_req,
  input  logic       host_ch,
  input  logic       err_clr,
  input  logic       eng_done,
  input  logic [7:0] eng_data,
  output logic       eng_start,
  output logic       eng_ch,
  output logic [7:0] cap_v,
  output logic [7:0] pow_v,
  output logic       cap_full,
  output logic       pow_low,
  output logic [7:0] host_data,
  output logic       host_valid,
  output logic       host_busy,
  output logic       timeout_err
);

  localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE} state_t;
  typedef enum logic [1:0] {SRC_HOST, SRC_CAP, SRC_POW} src_t;

  state_t        state, state_nx;
  src_t          src, src_nx;
  logic          ch_nx;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic [TW-1:0] timer;
  logic          tick;
  logic          pend_host, pend_cap, pend_pow, host_ch_q;
  logic          store_en, timeout_hit, serve_clr;

  // Scan timer free-runs regardless of what the engine is doing.
  assign tick = (timer == TIMER_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timer <= '0;
    else if (tick) timer <= '0;
    else           timer <= timer + 1'b1;
  end

  // NOTE: every always_comb output gets a default before the case statement,
  // otherwise unassigned paths would infer latches.
  always_comb begin
    state_nx    = state;
    src_nx      = src;
    ch_nx       = eng_ch;
    wcnt_nx     = wcnt;
    store_en    = 1'b0;
    timeout_hit = 1'b0;
    serve_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_host) begin
          state_nx = S_ISSUE;
          src_nx   = SRC_HOST;
          ch_nx    = host_ch_q;
        end else if (pend_cap) begin
          state_nx = S_ISSUE;
          src_nx   = SRC_CAP;
          ch_nx    = 1'b0;
        end else if (pend_pow) begin
          state_nx = S_ISSUE;
          src_nx   = SRC_POW;
          ch_nx    = 1'b1;
        end
      end
      S_ISSUE: begin
        wcnt_nx  = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          store_en = 1'b1;
          state_nx = S_STORE;
        end else if (wcnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          serve_clr   = 1'b1;
          state_nx    = S_IDLE;
        end else begin
          wcnt_nx = wcnt + 1'b1;
        end
      end
      S_STORE: begin
        serve_clr = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      src    <= SRC_HOST;
      eng_ch <= 1'b0;
      wcnt   <= '0;
    end else begin
      state  <= state_nx;
      src    <= src_nx;
      eng_ch <= ch_nx;
      wcnt   <= wcnt_nx;
    end
  end

  // A tick landing on the cycle that retires a channel re-arms it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_host <= 1'b0;
      pend_cap  <= 1'b0;
      pend_pow  <= 1'b0;
      host_ch_q <= 1'b0;
    end else begin
      if (host_req && !pend_host) begin
        pend_host <= 1'b1;
        host_ch_q <= host_ch;
      end else if (serve_clr && src == SRC_HOST) begin
        pend_host <= 1'b0;
      end
      pend_cap <= tick | (pend_cap & ~(serve_clr & (src == SRC_CAP)));
      pend_pow <= tick | (pend_pow & ~(serve_clr & (src == SRC_POW)));
    end
  end

  // Results land on the eng_done edge so they are visible in the STORE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_v     <= '0;
      pow_v     <= '0;
      cap_full  <= 1'b0;
      pow_low   <= 1'b0;
      host_data <= '0;
    end else if (store_en) begin
      if (!eng_ch) begin
        cap_v    <= eng_data;
        cap_full <= (eng_data >= CAP_FULL);
      end else begin
        pow_v    <= eng_data;
        pow_low  <= (eng_data < POW_LOW);
      end
      if (src == SRC_HOST) host_data <= eng_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
    else if (err_clr)     timeout_err <= 1'b0;
  end

  assign eng_start  = (state == S_ISSUE);
  assign host_valid = (state == S_STORE) && (src == SRC_HOST);
  assign host_busy  = pend_host;

endmodule

// File: doc/adc_conv_sched.md
ADC_CONV_SCHED -- requirements
Module: adc_conv_sched

Interface
REQ-001 Parameter SCAN_DIV, 50000, clk cycles between automatic scan ticks.
REQ-002 Parameter TIMEOUT, 4096, max clk cycles waiting for engine completion.
REQ-003 Parameter CAP_FULL, 8'd200, kicker capacitor full threshold (inclusive).
REQ-004 Parameter POW_LOW, 8'd150, battery low threshold (exclusive).
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 host_req  input  1  one-cycle host conversion request pulse.
REQ-008 host_ch  input  1  host channel select, sampled with host_req (0=cap, 1=pow).
REQ-009 err_clr  input  1  one-cycle pulse clearing timeout_err.
REQ-010 eng_done  input  1  one-cycle completion pulse from serial ADC engine.
REQ-011 eng_data  input  8  conversion result, valid while eng_done=1.
REQ-012 eng_start  output  1  one-cycle conversion start pulse to engine.
REQ-013 eng_ch  output  1  channel for engine, stable from eng_start until completion or timeout.
REQ-014 cap_v / pow_v  output  8 each  last stored capacitor / power voltage.
REQ-015 cap_full / pow_low  output  1 each  registered threshold flags.
REQ-016 host_data  output  8  result of last host conversion; host_valid  output  1  one-cycle pulse when host_data updates.
REQ-017 host_busy  output  1  host request pending or in service.
REQ-018 timeout_err  output  1  sticky engine-timeout flag.

Function
REQ-019 Scan timer SHALL count 0..SCAN_DIV-1, wrap to 0, and emit tick at SCAN_DIV-1; tick SHALL set pend_cap and pend_pow.
REQ-020 Tick while a pend bit is already set SHALL merge (no queuing of a second request per channel).
REQ-021 host_req while host_busy=0 SHALL latch pend_host and host_ch; host_req while host_busy=1 SHALL be ignored.
REQ-022 FSM states: IDLE, ISSUE, WAIT, STORE.
REQ-023 IDLE: if any pend bit set, select source by fixed priority host > cap > pow, drive eng_ch, go ISSUE next cycle.
REQ-024 ISSUE: eng_start=1 for exactly this cycle, clear wait counter, go WAIT.
REQ-025 WAIT: on eng_done capture eng_data and go STORE; wait counter reaching TIMEOUT-1 without eng_done SHALL go IDLE, set timeout_err, clear served pend bit, leave results unchanged.
REQ-026 STORE (one cycle): write captured data to cap_v or pow_v per eng_ch; host source additionally updates host_data and pulses host_valid; clear served pend bit; go IDLE.
REQ-027 Host conversion SHALL also update the matching cap_v/pow_v and flags.
REQ-028 cap_full SHALL be registered as (cap_v_new >= CAP_FULL) and pow_low as (pow_v_new < POW_LOW), updated only in STORE for their channel.
REQ-029 eng_done outside WAIT SHALL be ignored.
REQ-030 Minimum latency: pend set -> eng_start 2 cycles; eng_done -> cap_v/pow_v/host_valid 1 cycle.
REQ-031 err_clr SHALL clear timeout_err; timeout set and err_clr in same cycle SHALL leave timeout_err=1.
REQ-032 Scan timer SHALL run independently of FSM state.

Reset
REQ-033 reset_n low SHALL immediately force FSM IDLE, timer 0, all pend bits 0, and all outputs 0 (cap_v, pow_v, host_data, flags, eng_start, eng_ch, host_valid, host_busy, timeout_err).
REQ-034 Reset mid-WAIT SHALL abandon the conversion with no result stored; engine shares reset_n.

Verification
REQ-035 SCAN_DIV=16, engine returns 0xC8 on ch0 and 0x90 on ch1 after 20 cycles -> eng_start ch0 then ch1; cap_v=0xC8, cap_full=1, pow_v=0x90, pow_low=1.
REQ-036 host_req ch1 in same cycle as tick -> host served first (eng_ch=1), host_valid pulse with host_data=eng_data, then cap, then pow.
REQ-037 Second host_req while host_busy=1 -> ignored, exactly one host_valid pulse.
REQ-038 Engine never asserts eng_done, TIMEOUT=64 -> IDLE after 64 WAIT cycles, timeout_err=1, cap_v unchanged; err_clr -> timeout_err=0.
REQ-039 reset_n low during WAIT then eng_done after release -> no register update, outputs 0.
REQ-040 eng_done pulse while IDLE -> no state change, no register update.
